// File: rtl/afe_spi_pkg.sv
// ---------------------------------------------------------------------------
// afe_spi_pkg
// Shared definitions for the multi-lane AFE SPI controller:
//   - spi_state_t    : controller state encoding (IDLE, SHIFT, LATCH, GAP)
//   - chan_sel_width : width of the lane-select field for a given lane count
//   - bit_cnt_width  : width of the bit counter for a given word width
//   - DEFAULT_DATA_WIDTH / DEFAULT_CLK_DIV : default build configuration
// ---------------------------------------------------------------------------
package afe_spi_pkg;

    localparam int DEFAULT_DATA_WIDTH = 24;
    localparam int DEFAULT_CLK_DIV    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2,
        GAP   = 2'd3
    } spi_state_t;

    // A single lane still needs a one-bit select field so the port exists.
    function automatic int chan_sel_width(input int channel_count);
        return (channel_count > 1) ? $clog2(channel_count) : 1;
    endfunction

    function automatic int bit_cnt_width(input int data_width);
        return (data_width > 1) ? $clog2(data_width) : 1;
    endfunction

endpackage

// File: rtl/afe_spi_multi_ctrl_tick.sv
// ---------------------------------------------------------------------------
// afe_spi_tick
// SPI half-period divider. Emits a one-cycle tick on the last sysClk cycle of
// every CLK_DIV-cycle half period while enabled.
// Ports:
//   sysClk      in   system clock
//   sysReset_n  in   synchronous reset, active low
//   restart     in   force the divider back to the start of a half period
//   enable      in   advance the divider
//   tick        out  last cycle of the current half period
// ---------------------------------------------------------------------------
module afe_spi_tick #(
    parameter int CLK_DIV = 8
) (
    input  logic sysClk,
    input  logic sysReset_n,
    input  logic restart,
    input  logic enable,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;

    // Restart on accept so the first half period after a command is exactly
    // CLK_DIV cycles long regardless of where the free count had wandered.
    always_ff @(posedge sysClk) begin
        if (!sysReset_n || restart) begin
            div_cnt <= '0;
        end else if (enable) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/afe_spi_multi_ctrl.sv
// ---------------------------------------------------------------------------
// afe_spi_multi_ctrl
// N-lane write-mostly SPI master for the AFE attenuator/switch chips.
// A command shifts DATA_WIDTH bits MSB first on one lane (or all lanes in
// broadcast), pulses LE for 2*CLK_DIV cycles, then idles GAP_CYCLES cycles.
// Ports:
//   sysClk, sysReset_n   clock and synchronous active-low reset
//   cmdValid/cmdReady    command handshake (cmdReady is a register)
//   cmdChannel           target lane, ignored when cmdBroadcast=1
//   cmdBroadcast         drive every lane with the same word
//   cmdData              word to shift
//   busy                 transaction in progress
//   doneStrobe           one-cycle pulse at end of each accepted command
//   cmdError             one-cycle pulse for an out-of-range lane
//   AFE_SPI_CLK/SDI/LE   per-lane registered SPI pins
// Optional build macro AFE_SPI_READBACK_EN adds:
//   AFE_SPI_SDO          per-lane serial data from the devices
//   rdData               last word read back, updated on doneStrobe
// ---------------------------------------------------------------------------
module afe_spi_multi_ctrl
    import afe_spi_pkg::*;
#(
    parameter int CHANNEL_COUNT = 2,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int CLK_DIV       = DEFAULT_CLK_DIV,
    parameter int GAP_CYCLES    = 8
) (
    input  logic                                     sysClk,
    input  logic                                     sysReset_n,
    input  logic                                     cmdValid,
    output logic                                     cmdReady,
    input  logic [chan_sel_width(CHANNEL_COUNT)-1:0] cmdChannel,
    input  logic                                     cmdBroadcast,
    input  logic [DATA_WIDTH-1:0]                    cmdData,
`ifdef AFE_SPI_READBACK_EN
    input  logic [CHANNEL_COUNT-1:0]                 AFE_SPI_SDO,
    output logic [DATA_WIDTH-1:0]                    rdData,
`endif
    output logic                                     busy,
    output logic                                     doneStrobe,
    output logic                                     cmdError,
    output logic [CHANNEL_COUNT-1:0]                 AFE_SPI_CLK,
    output logic [CHANNEL_COUNT-1:0]                 AFE_SPI_SDI,
    output logic [CHANNEL_COUNT-1:0]                 AFE_SPI_LE
);

    localparam int CSW = chan_sel_width(CHANNEL_COUNT);
    localparam int BCW = bit_cnt_width(DATA_WIDTH);
    localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GCW-1:0] GAP_LAST   = GCW'(GAP_CYCLES - 1);
    localparam logic [BCW-1:0] BIT_FIRST  = BCW'(DATA_WIDTH - 1);
    localparam logic [CSW:0]   CHAN_LIMIT = (CSW + 1)'(CHANNEL_COUNT);

    spi_state_t               state, state_n;
    logic [BCW-1:0]           bit_cnt, bit_cnt_n;
    logic                     phase, phase_n;
    logic [GCW-1:0]           gap_cnt, gap_cnt_n;
    logic [DATA_WIDTH-1:0]    shift_reg, shift_n;
    logic [CHANNEL_COUNT-1:0] lane_mask, mask_n;

    logic [CHANNEL_COUNT-1:0] spi_clk_n, spi_sdi_n, spi_le_n;
    logic                     ready_n, busy_n, done_n, err_n;

    logic                     accept;
    logic                     chan_valid;
    logic [CHANNEL_COUNT-1:0] sel_mask;
    logic                     tick;

    assign accept     = cmdValid && cmdReady;
    assign chan_valid = cmdBroadcast || ({1'b0, cmdChannel} < CHAN_LIMIT);

    // Lane decode for the incoming command; an invalid lane selects nothing.
    always_comb begin
        sel_mask = '0;
        if (cmdBroadcast) begin
            sel_mask = '1;
        end else if (chan_valid) begin
            sel_mask = CHANNEL_COUNT'(1) << cmdChannel;
        end
    end

    afe_spi_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .sysClk     (sysClk),
        .sysReset_n (sysReset_n),
        .restart    (accept),
        .enable     ((state == SHIFT) || (state == LATCH)),
        .tick       (tick)
    );

    // State register. Pins and status outputs are registered here from their
    // next-cycle values so every output comes straight from a flop.
    always_ff @(posedge sysClk) begin
        if (!sysReset_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            phase       <= 1'b0;
            gap_cnt     <= '0;
            shift_reg   <= '0;
            lane_mask   <= '0;
            AFE_SPI_CLK <= '0;
            AFE_SPI_SDI <= '0;
            AFE_SPI_LE  <= '0;
            cmdReady    <= 1'b1;
            busy        <= 1'b0;
            doneStrobe  <= 1'b0;
            cmdError    <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            phase       <= phase_n;
            gap_cnt     <= gap_cnt_n;
            shift_reg   <= shift_n;
            lane_mask   <= mask_n;
            AFE_SPI_CLK <= spi_clk_n;
            AFE_SPI_SDI <= spi_sdi_n;
            AFE_SPI_LE  <= spi_le_n;
            cmdReady    <= ready_n;
            busy        <= busy_n;
            doneStrobe  <= done_n;
            cmdError    <= err_n;
        end
    end

    // Next-state logic. phase=0 is the CLK-low half of a bit, phase=1 the
    // CLK-high half; LATCH reuses the same two halves for its 2*CLK_DIV
    // cycles. An invalid lane jumps straight to the final GAP cycle so the
    // error and done pulses land on the cycle after accept.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        phase_n   = phase;
        gap_cnt_n = gap_cnt;
        shift_n   = shift_reg;
        mask_n    = lane_mask;
        case (state)
            IDLE: begin
                if (accept) begin
                    mask_n    = sel_mask;
                    shift_n   = cmdData;
                    bit_cnt_n = BIT_FIRST;
                    phase_n   = 1'b0;
                    if (chan_valid) begin
                        state_n = SHIFT;
                    end else begin
                        state_n   = GAP;
                        gap_cnt_n = GAP_LAST;
                    end
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!phase) begin
                        phase_n = 1'b1;
                    end else begin
                        phase_n = 1'b0;
                        if (bit_cnt == '0) begin
                            state_n = LATCH;
                        end else begin
                            bit_cnt_n = bit_cnt - 1'b1;
                            shift_n   = {shift_reg[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
            end
            LATCH: begin
                if (tick) begin
                    if (!phase) begin
                        phase_n = 1'b1;
                    end else begin
                        phase_n   = 1'b0;
                        state_n   = GAP;
                        gap_cnt_n = '0;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = IDLE;
                    mask_n  = '0;
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Output decode from next-state values; unselected lanes are masked to 0.
    always_comb begin
        spi_clk_n = {CHANNEL_COUNT{(state_n == SHIFT) && phase_n}} & mask_n;
        spi_sdi_n = {CHANNEL_COUNT{(state_n == SHIFT) && shift_n[DATA_WIDTH-1]}} & mask_n;
        spi_le_n  = {CHANNEL_COUNT{state_n == LATCH}} & mask_n;
        ready_n   = (state_n == IDLE);
        busy_n    = (state_n != IDLE);
        done_n    = (state_n == GAP) && (gap_cnt_n == GAP_LAST);
        err_n     = accept && !chan_valid;
    end

`ifdef AFE_SPI_READBACK_EN
    logic [CSW-1:0]        rd_lane;
    logic [DATA_WIDTH-1:0] rd_shift;
    logic                  rd_capture;

    // Sample SDO on the last CLK-high cycle of each bit, i.e. the cycle
    // before CLK falls, so the device has had a full high phase to drive it.
    assign rd_capture = (state == SHIFT) && phase && tick;

    // Readback capture; the invalid-lane done pulse (done_n with accept)
    // must leave rdData untouched.
    always_ff @(posedge sysClk) begin
        if (!sysReset_n) begin
            rd_lane  <= '0;
            rd_shift <= '0;
            rdData   <= '0;
        end else begin
            if (accept) begin
                rd_lane <= cmdBroadcast ? '0 : cmdChannel;
            end
            if (rd_capture) begin
                rd_shift <= {rd_shift[DATA_WIDTH-2:0], AFE_SPI_SDO[rd_lane]};
            end
            if (done_n && !accept) begin
                rdData <= rd_shift;
            end
        end
    end
`endif

endmodule

// File: tb/tb_afe_spi_multi_ctrl.sv
// ---------------------------------------------------------------------------
// tb_afe_spi_multi_ctrl
// Directed bench for afe_spi_multi_ctrl. Instance A: 4 lanes, 8-bit words,
// CLK_DIV=2, GAP=2. Instance B: same but 5 lanes, so a 3-bit cmdChannel can
// name the out-of-range lane 5. Readback checks exist when
// AFE_SPI_READBACK_EN is defined.
// ---------------------------------------------------------------------------
module tb_afe_spi_multi_ctrl;

    localparam int CD        = 2;
    localparam int DW        = 8;
    localparam int GAPC      = 2;
    // Expected timing, counted from the accept cycle (cycle 0).
    localparam int RISE_FIRST = CD + 1;
    localparam int RISE_LAST  = (DW - 1) * 2 * CD + CD + 1;
    localparam int LE_FIRST   = DW * 2 * CD + 1;
    localparam int LE_LAST    = DW * 2 * CD + 2 * CD;
    localparam int DONE_CYC   = DW * 2 * CD + 2 * CD + GAPC;

    logic       sysClk;
    logic       sysReset_n;

    logic       a_valid, a_ready, a_bcast, a_busy, a_done, a_err;
    logic [1:0] a_chan;
    logic [7:0] a_data;
    logic [3:0] a_clk, a_sdi, a_le;

    logic       b_valid, b_ready, b_bcast, b_busy, b_done, b_err;
    logic [2:0] b_chan;
    logic [7:0] b_data;
    logic [4:0] b_clk, b_sdi, b_le;

`ifdef AFE_SPI_READBACK_EN
    logic [3:0] a_sdo;
    logic [7:0] a_rd;
    logic [4:0] b_sdo;
    logic [7:0] b_rd;
`endif

    int checks_total;
    int checks_passed;
    int checks_failed;
    int cyc;

    typedef struct {
        logic [3:0] mask;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    afe_spi_multi_ctrl #(
        .CHANNEL_COUNT (4), .DATA_WIDTH (DW), .CLK_DIV (CD), .GAP_CYCLES (GAPC)
    ) dut_a (
        .sysClk       (sysClk),
        .sysReset_n   (sysReset_n),
        .cmdValid     (a_valid),
        .cmdReady     (a_ready),
        .cmdChannel   (a_chan),
        .cmdBroadcast (a_bcast),
        .cmdData      (a_data),
`ifdef AFE_SPI_READBACK_EN
        .AFE_SPI_SDO  (a_sdo),
        .rdData       (a_rd),
`endif
        .busy         (a_busy),
        .doneStrobe   (a_done),
        .cmdError     (a_err),
        .AFE_SPI_CLK  (a_clk),
        .AFE_SPI_SDI  (a_sdi),
        .AFE_SPI_LE   (a_le)
    );

    afe_spi_multi_ctrl #(
        .CHANNEL_COUNT (5), .DATA_WIDTH (DW), .CLK_DIV (CD), .GAP_CYCLES (GAPC)
    ) dut_b (
        .sysClk       (sysClk),
        .sysReset_n   (sysReset_n),
        .cmdValid     (b_valid),
        .cmdReady     (b_ready),
        .cmdChannel   (b_chan),
        .cmdBroadcast (b_bcast),
        .cmdData      (b_data),
`ifdef AFE_SPI_READBACK_EN
        .AFE_SPI_SDO  (b_sdo),
        .rdData       (b_rd),
`endif
        .busy         (b_busy),
        .doneStrobe   (b_done),
        .cmdError     (b_err),
        .AFE_SPI_CLK  (b_clk),
        .AFE_SPI_SDI  (b_sdi),
        .AFE_SPI_LE   (b_le)
    );

    initial begin
        sysClk = 1'b0;
        forever #5 sysClk = ~sysClk;
    end

`ifdef AFE_SPI_READBACK_EN
    // Device model on B lane 1: shifts out 0x5A MSB first, advancing one bit
    // after every CLK falling edge.
    logic [7:0] rb_pattern;
    logic       rb_prev_clk;
    int         rb_falls;

    assign rb_pattern = 8'h5A;
    assign a_sdo      = '0;

    always @(negedge sysClk) begin
        rb_prev_clk <= b_clk[1];
        if (!b_busy) begin
            rb_falls <= 0;
        end else if (rb_prev_clk && !b_clk[1]) begin
            rb_falls <= rb_falls + 1;
        end
    end

    always_comb begin
        b_sdo = '0;
        if (rb_falls < 8) begin
            b_sdo[1] = rb_pattern[3'(7 - rb_falls)];
        end
    end
`endif

    // Compare one observed value with its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else begin
            checks_failed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic stepCycle();
        @(posedge sysClk);
        #1;
        cyc++;
    endtask

    // Issue a command on instance A at the current cycle (cycle 0), push its
    // expected lane word to the scoreboard, and step into cycle 1.
    task automatic applyStimulus(input logic [7:0] data, input logic [1:0] chan,
                                 input logic bcast, input logic hold);
        exp_t e;
        int   guard;
        guard = 0;
        while (!a_ready && guard < 200) begin
            stepCycle();
            guard++;
        end
        if (guard >= 200) checkOutput("ready_wait", a_ready, 1);
        cyc     = 0;
        a_data  = data;
        a_chan  = chan;
        a_bcast = bcast;
        a_valid = 1'b1;
        e.mask  = bcast ? 4'hF : (4'b0001 << chan);
        e.data  = data;
        sb.push_back(e);
        stepCycle();
        if (!hold) a_valid = 1'b0;
    endtask

    // Watch instance A from cycle 1 to doneStrobe, rebuild each lane's word
    // from SDI at CLK rising edges, then pop and compare the scoreboard.
    task automatic monitorTxn(input string tag);
        exp_t       e;
        logic [7:0] word [4];
        logic [3:0] prev_clk, prev_sdi;
        int         rises, first_rise, last_rise;
        int         le_cnt, le_first, le_last, done_cyc;
        bit         lane_bad, sdi_bad, ready_bad, err_bad, busy_bad;
        if (sb.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb[0];
        for (int l = 0; l < 4; l++) word[l] = '0;
        prev_clk = '0; prev_sdi = '0;
        rises = 0; first_rise = -1; last_rise = -1;
        le_cnt = 0; le_first = -1; le_last = -1; done_cyc = -1;
        lane_bad = 0; sdi_bad = 0; ready_bad = 0; err_bad = 0; busy_bad = 0;
        for (int k = 0; k < 200; k++) begin
            for (int l = 0; l < 4; l++) begin
                if (a_clk[l] && !prev_clk[l]) word[l] = {word[l][6:0], a_sdi[l]};
            end
            if ((a_clk & e.mask) != 0 && (prev_clk & e.mask) == 0) begin
                rises++;
                if (first_rise < 0) first_rise = cyc;
                last_rise = cyc;
            end
            if ((a_clk & ~e.mask) != 0 || (a_clk != 0 && a_clk != e.mask)) lane_bad = 1;
            if ((a_sdi & ~e.mask) != 0 || (a_sdi != 0 && a_sdi != e.mask)) lane_bad = 1;
            if ((a_le & ~e.mask) != 0 || (a_le != 0 && a_le != e.mask)) lane_bad = 1;
            if ((a_clk & e.mask) != 0 && a_sdi != prev_sdi) sdi_bad = 1;
            if ((a_le & e.mask) != 0) begin
                le_cnt++;
                if (le_first < 0) le_first = cyc;
                le_last = cyc;
            end
            if (a_ready) ready_bad = 1;
            if (a_err) err_bad = 1;
            if (!a_busy) busy_bad = 1;
            if (a_done) begin
                done_cyc = cyc;
                break;
            end
            prev_clk = a_clk;
            prev_sdi = a_sdi;
            stepCycle();
        end
        checkOutput({tag, "_done_cycle"}, done_cyc, DONE_CYC);
        e = sb.pop_front();
        for (int l = 0; l < 4; l++) begin
            if (e.mask[l]) checkOutput($sformatf("%s_word_lane%0d", tag, l), word[l], e.data);
        end
        checkOutput({tag, "_rise_count"}, rises, DW);
        checkOutput({tag, "_rise_first"}, first_rise, RISE_FIRST);
        checkOutput({tag, "_rise_last"}, last_rise, RISE_LAST);
        checkOutput({tag, "_le_count"}, le_cnt, 2 * CD);
        checkOutput({tag, "_le_first"}, le_first, LE_FIRST);
        checkOutput({tag, "_le_last"}, le_last, LE_LAST);
        checkOutput({tag, "_lane_shape"}, lane_bad, 0);
        checkOutput({tag, "_sdi_stable_high"}, sdi_bad, 0);
        checkOutput({tag, "_ready_low"}, ready_bad, 0);
        checkOutput({tag, "_no_error"}, err_bad, 0);
        checkOutput({tag, "_busy_high"}, busy_bad, 0);
    endtask

    // Step instance B until doneStrobe, bounded, and check its cycle.
    task automatic waitDoneB(input string tag);
        int done_cyc;
        done_cyc = -1;
        for (int k = 0; k < 200; k++) begin
            if (b_done) begin
                done_cyc = cyc;
                break;
            end
            stepCycle();
        end
        checkOutput({tag, "_done_cycle"}, done_cyc, DONE_CYC);
    endtask

    initial begin
        bit le_seen, done_seen;
        checks_total = 0; checks_passed = 0; checks_failed = 0; cyc = 0;
        sysReset_n = 1'b0;
        a_valid = 0; a_chan = 0; a_bcast = 0; a_data = 0;
        b_valid = 0; b_chan = 0; b_bcast = 0; b_data = 0;
        stepCycle();
        stepCycle();

        // Reset state
        checkOutput("rst_ready", a_ready, 1);
        checkOutput("rst_busy", a_busy, 0);
        checkOutput("rst_done_err", {a_done, a_err}, 0);
        checkOutput("rst_pins_a", {a_clk, a_sdi, a_le}, 0);
        checkOutput("rst_pins_b", {b_ready, b_clk, b_sdi, b_le}, {1'b1, 15'h0});
        sysReset_n = 1'b1;
        stepCycle();

        // Single lane write, 0xA5 to lane 2
        applyStimulus(8'hA5, 2'd2, 1'b0, 1'b0);
        monitorTxn("ch2");
        stepCycle();
        checkOutput("ch2_ready_after", a_ready, 1);
        checkOutput("ch2_single_done", {a_done, a_busy}, 0);

        // Broadcast 0x3C to all lanes
        stepCycle();
        applyStimulus(8'h3C, 2'd0, 1'b1, 1'b0);
        monitorTxn("bcast");
        stepCycle();
        checkOutput("bcast_single_done", a_done, 0);

        // Back-to-back with cmdValid held across the first transaction
        stepCycle();
        applyStimulus(8'hC3, 2'd1, 1'b0, 1'b1);
        a_data = 8'h96;
        monitorTxn("b2b_w1");
        stepCycle();
        checkOutput("b2b_ready_at_39", a_ready, 1);
        applyStimulus(8'h96, 2'd1, 1'b0, 1'b0);
        monitorTxn("b2b_w2");
        stepCycle();
        checkOutput("b2b_no_third", {a_ready, a_busy}, 2'b10);

        // Reset during the shift phase
        stepCycle();
        applyStimulus(8'hFF, 2'd0, 1'b0, 1'b0);
        while (cyc < 15) stepCycle();
        checkOutput("rstmid_busy_before", a_busy, 1);
        sysReset_n = 1'b0;
        stepCycle();
        sb.delete();
        checkOutput("rstmid_pins", {a_clk, a_sdi, a_le}, 0);
        checkOutput("rstmid_status", {a_ready, a_busy, a_done}, 3'b100);
        sysReset_n = 1'b1;
        le_seen = 0; done_seen = 0;
        for (int k = 0; k < 60; k++) begin
            if (a_le != 0) le_seen = 1;
            if (a_done) done_seen = 1;
            stepCycle();
        end
        checkOutput("rstmid_no_le", le_seen, 0);
        checkOutput("rstmid_no_done", done_seen, 0);

        // Invalid lane on the 5-lane instance
        cyc = 0;
        b_chan = 3'd5; b_bcast = 1'b0; b_data = 8'hFF; b_valid = 1'b1;
        stepCycle();
        b_valid = 1'b0;
        checkOutput("inv_c1_err_done", {b_err, b_done}, 2'b11);
        checkOutput("inv_c1_ready", b_ready, 0);
        checkOutput("inv_c1_pins", {b_clk, b_sdi, b_le}, 0);
        stepCycle();
        checkOutput("inv_c2_ready", b_ready, 1);
        checkOutput("inv_c2_quiet", {b_err, b_done, b_clk, b_sdi, b_le}, 0);

        // Highest valid lane on the 5-lane instance
        cyc = 0;
        b_chan = 3'd4; b_data = 8'h81; b_valid = 1'b1;
        stepCycle();
        b_valid = 1'b0;
        checkOutput("lane4_no_err", {b_err, b_busy}, 2'b01);
        waitDoneB("lane4");
        stepCycle();

`ifdef AFE_SPI_READBACK_EN
        // Readback of 0x5A from lane 1, held through an invalid command
        cyc = 0;
        b_chan = 3'd1; b_data = 8'h00; b_valid = 1'b1;
        stepCycle();
        b_valid = 1'b0;
        waitDoneB("rb");
        checkOutput("rb_data_at_done", b_rd, 8'h5A);
        stepCycle();
        cyc = 0;
        b_chan = 3'd5; b_valid = 1'b1;
        stepCycle();
        b_valid = 1'b0;
        checkOutput("rb_inv_done", b_done, 1);
        checkOutput("rb_hold_inv", b_rd, 8'h5A);
        stepCycle();
        checkOutput("rb_hold_after", b_rd, 8'h5A);
`endif

        checkOutput("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
